mem_access_seq: RTL and testbench
=================================

# mem_access_seq

- Array-side sequencer that sits directly downstream of the access-control FSM.
- Consumes the FSM's `valid`/`rw` command pulse together with an address and write data.
- Generates the cycle-accurate strobe sequence for a small SRAM-style array: precharge, wordline, then sense-amp or write-driver.
- Holds the array contents as a behavioural register model and returns read data with a one-cycle valid pulse.

## Interface
Parameters:
- `ADDR_W`, default 2: address width; array depth is 2^ADDR_W words.
- `DATA_W`, default 4: word width.
- `PRE_CYCLES`, default 2: precharge length in cycles; legal range 1..15.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `valid` input 1: command strobe from the control FSM.
- `rw` input 1: 1 = write, 0 = read; sampled only with `valid`.
- `addr` input ADDR_W: word address; sampled only with `valid`.
- `wdata` input DATA_W: write data; sampled only with `valid`.
- `ready` output 1: high only in IDLE.
- `precharge` output 1: bitline precharge strobe.
- `wl` output 2^ADDR_W: one-hot wordline enable.
- `sae` output 1: sense-amp enable.
- `wde` output 1: write-driver enable.
- `rdata` output DATA_W: read data, held until the next read completes.
- `rdata_valid` output 1: one-cycle pulse when `rdata` updates.
- `req_dropped` output 1: one-cycle pulse when `valid` arrives while busy.

## Operation
- **Accept:** a command is accepted on the edge where `valid && ready`. `rw`, `addr` and `wdata` are registered at that edge.
- **States and transitions:**
  - IDLE → PRE on accept.
  - PRE → ACT after PRE_CYCLES cycles, counted by a 4-bit down-counter.
  - ACT → XFER after 1 cycle.
  - XFER → DONE after 1 cycle.
  - DONE → IDLE after 1 cycle.
- **Outputs per state:**
  - PRE: `precharge`=1.
  - ACT: `wl[addr]`=1.
  - XFER: `wl[addr]`=1; `sae`=1 for a read, `wde`=1 for a write.
    - Write: the array word is updated at the XFER→DONE edge.
    - Read: `rdata` is loaded at the same edge.
  - DONE: `rdata_valid`=1 for a read, 0 for a write. All strobes are 0.
- **Strobe rules:**
  - `precharge`, `sae` and `wde` are mutually exclusive.
  - `wl` is never asserted together with `precharge`.
- **Busy:** `valid` in any non-IDLE state is ignored. It produces a `req_dropped` pulse on the following cycle. No command is queued.
- **Back-to-back:** a new `valid` in the first IDLE cycle after DONE is accepted.
- **Read-after-write:** a read of the same address issued after a write's DONE returns the new data.
- **Registered outputs:** all outputs are registered except `ready`, which is decoded from state.

## Timing
- Accept edge is E0.
- PRE occupies cycles 1..P, where P = PRE_CYCLES.
- ACT is cycle P+1, XFER is cycle P+2, DONE is cycle P+3.
- `ready` is high again in cycle P+4.
- Read latency from accept edge to `rdata_valid`: P+3 cycles, which is 5 at defaults.
- Command throughput is one per P+4 cycles.
- Reset values: `ready`=1; `precharge`, `wl`, `sae`, `wde`, `rdata`, `rdata_valid`, `req_dropped`=0; all array words=0; state=IDLE.
- Reset mid-operation:
  - Everything returns to reset values immediately.
  - A write whose XFER→DONE edge has not occurred is not committed.
  - `rdata` is cleared to 0.

## Configuration
- Macro `MEM_SEQ_PARITY_EN`.
- **Defined:**
  - Each word stores an extra even-parity bit, computed from `wdata` at accept.
  - Adds input `par_inj` (1 bit), sampled with `valid` on writes. When 1, the stored parity bit is inverted.
  - Adds output `parity_err` (1 bit, reset 0). It pulses together with `rdata_valid` when the stored parity does not match the read word.
  - Reset-cleared words hold parity 0, which is consistent.
- **Undefined:** no parity storage, and the `par_inj`/`parity_err` ports are absent.

## Test plan
- Reset, then write `addr`=2, `wdata`=4'hA → `precharge` high cycles 1–2, `wl`=4'b0100 cycles 3–4, `wde` high cycle 4, `ready` high at cycle 6.
- Then read `addr`=2 → `sae` high cycle 4, `rdata`=4'hA with `rdata_valid` pulse at cycle 5; read `addr`=1 → `rdata`=0.
- Pulse `valid` during PRE of a write → `req_dropped` pulse next cycle, array and sequence unaffected.
- Assert `rst_n`=0 during ACT of a write of 4'h5 to addr 0, then read addr 0 → `rdata`=0, and all strobes 0 immediately on reset.
- PRE_CYCLES=1, two writes back-to-back (second `valid` the first IDLE cycle) → both accepted, accept edges 5 cycles apart, no `req_dropped`.
- With `MEM_SEQ_PARITY_EN`: write 4'h3 with `par_inj`=1, then read → `parity_err`=1 with `rdata_valid`; rewrite with `par_inj`=0, then read → `parity_err`=0.

Source files
------------

// File: rtl/mem_access_seq.sv
// mem_access_seq: strobe sequencer (precharge -> wordline -> sense/write) for a small SRAM-style array.
// Defining MEM_SEQ_PARITY_EN adds a stored even-parity bit per word, the par_inj input and the parity_err output.
module mem_access_seq #(
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 4,
    parameter int PRE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid,
    input  logic                   rw,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    output logic                   ready,
    output logic                   precharge,
    output logic [(1<<ADDR_W)-1:0] wl,
    output logic                   sae,
    output logic                   wde,
    output logic [DATA_W-1:0]      rdata,
    output logic                   rdata_valid,
    output logic                   req_dropped
`ifdef MEM_SEQ_PARITY_EN
    ,
    input  logic                   par_inj,
    output logic                   parity_err
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef MEM_SEQ_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
    logic [WORD_W-1:0] word_in;
    assign word_in = {(^wdata) ^ par_inj, wdata};
`else
    localparam int WORD_W = DATA_W;
    logic [WORD_W-1:0] word_in;
    assign word_in = wdata;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACT,
        S_XFER,
        S_DONE
    } state_e;

    state_e              state;
    state_e              state_nxt;
    logic [3:0]          cnt;
    logic [3:0]          cnt_nxt;
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wword_q;
    logic [WORD_W-1:0]   mem [DEPTH];
    logic [WORD_W-1:0]   rd_word;
    logic                accept;
    logic                pre_nxt;
    logic [DEPTH-1:0]    wl_nxt;
    logic                sae_nxt;
    logic                wde_nxt;
    logic                rdv_nxt;

    assign ready   = (state == S_IDLE);
    assign accept  = valid && ready;
    assign rd_word = mem[addr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs are registered, so the strobes are decoded from the state being entered.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (valid) begin
                    state_nxt = S_PRE;
                    cnt_nxt   = 4'(PRE_CYCLES);
                end
            end
            S_PRE: begin
                if (cnt <= 4'd1) begin
                    state_nxt = S_ACT;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_ACT:   state_nxt = S_XFER;
            S_XFER:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        pre_nxt = (state_nxt == S_PRE);
        wl_nxt  = '0;
        if (state_nxt == S_ACT || state_nxt == S_XFER) begin
            wl_nxt[addr_q] = 1'b1;
        end
        sae_nxt = (state_nxt == S_XFER) && !rw_q;
        wde_nxt = (state_nxt == S_XFER) && rw_q;
        rdv_nxt = (state == S_XFER) && !rw_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wword_q <= '0;
        end else if (accept) begin
            rw_q    <= rw;
            addr_q  <= addr;
            wword_q <= word_in;
        end
    end

    // A write lands only on the XFER->DONE edge; a reset before then leaves the word untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == S_XFER && rw_q) begin
            mem[addr_q] <= wword_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            precharge   <= 1'b0;
            wl          <= '0;
            sae         <= 1'b0;
            wde         <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            req_dropped <= 1'b0;
`ifdef MEM_SEQ_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            precharge   <= pre_nxt;
            wl          <= wl_nxt;
            sae         <= sae_nxt;
            wde         <= wde_nxt;
            rdata_valid <= rdv_nxt;
            req_dropped <= valid && !ready;
            if (rdv_nxt) begin
                rdata <= rd_word[DATA_W-1:0];
            end
`ifdef MEM_SEQ_PARITY_EN
            // Even parity over data plus stored bit is zero for a consistent word.
            parity_err  <= rdv_nxt && (^rd_word);
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: randomized scoreboard bench for mem_access_seq; expected strobe timing
// is derived from each command's accept edge, expected data from a word-array model.
module tb_mem_access_seq;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;
    localparam int P      = 2;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef MEM_SEQ_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              valid;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              precharge;
    logic [DEPTH-1:0]  wl;
    logic              sae;
    logic              wde;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              req_dropped;
    logic              act_perr;
`ifdef MEM_SEQ_PARITY_EN
    logic              par_inj;
    logic              parity_err;
    assign act_perr = parity_err;
`else
    assign act_perr = 1'b0;
`endif

    mem_access_seq #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .PRE_CYCLES(P)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .valid(valid),
        .rw(rw),
        .addr(addr),
        .wdata(wdata),
        .ready(ready),
        .precharge(precharge),
        .wl(wl),
        .sae(sae),
        .wde(wde),
        .rdata(rdata),
        .rdata_valid(rdata_valid),
        .req_dropped(req_dropped)
`ifdef MEM_SEQ_PARITY_EN
        ,
        .par_inj(par_inj),
        .parity_err(parity_err)
`endif
    );

    typedef struct {
        int                e0;
        bit                rw;
        int                addr;
        logic [DATA_W-1:0] data;
        bit                perr;
    } txn_t;

    txn_t              txn_q[$];
    int                drop_q[$];
    logic [DATA_W-1:0] model_mem [DEPTH];
    bit                model_perr [DEPTH];
    int                vectors     = 0;
    int                miscompares = 0;
    int                cyc         = 0;
    int                last_e0     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]  = '0;
            model_perr[i] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic applyStimulus(input bit rw_i, input int a, input logic [DATA_W-1:0] d, input bit inj);
        txn_t t;
        int   n;
        n = 0;
        while (!ready && n < 50) begin
            idle(1);
            n++;
        end
        if (!ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL ready_timeout at cycle %0d: ready got 0 for 50 cycles, expected 1", cyc);
            return;
        end
        valid = 1'b1;
        rw    = rw_i;
        addr  = ADDR_W'(a);
        wdata = d;
`ifdef MEM_SEQ_PARITY_EN
        par_inj = inj;
`endif
        t.e0   = cyc + 1;
        t.rw   = rw_i;
        t.addr = a;
        t.perr = 1'b0;
        if (rw_i) begin
            model_mem[a]  = d;
            model_perr[a] = inj;
            t.data        = d;
        end else begin
            t.data = model_mem[a];
            t.perr = model_perr[a];
        end
        last_e0 = t.e0;
        txn_q.push_back(t);
        idle(1);
        valid = 1'b0;
    endtask

    task automatic tryDrop();
        if (!ready) begin
            valid = 1'b1;
            rw    = 1'($urandom);
            addr  = ADDR_W'($urandom);
            wdata = DATA_W'($urandom);
            drop_q.push_back(cyc + 1);
            idle(1);
            valid = 1'b0;
        end
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        valid = 1'b0;
        txn_q.delete();
        drop_q.delete();
        clearModel();
        idle(2);
        rst_n = 1'b1;
    endtask

    // Monitor: expected outputs for the cycle follow from the head command's accept edge.
    initial begin : monitor
        logic [DATA_W-1:0] hold;
        bit                e_ready, e_pre, e_sae, e_wde, e_rdv, e_drop, e_perr;
        logic [DEPTH-1:0]  e_wl;
        int                k;
        txn_t              t;
        hold = '0;
        forever begin
            @(negedge clk);
            e_ready = 1'b1;
            e_pre   = 1'b0;
            e_sae   = 1'b0;
            e_wde   = 1'b0;
            e_rdv   = 1'b0;
            e_drop  = 1'b0;
            e_perr  = 1'b0;
            e_wl    = '0;
            if (!rst_n) begin
                hold = '0;
            end else begin
                if (drop_q.size() > 0 && drop_q[0] == cyc) begin
                    e_drop = 1'b1;
                    void'(drop_q.pop_front());
                end
                if (txn_q.size() > 0 && cyc >= txn_q[0].e0) begin
                    t       = txn_q[0];
                    k       = cyc - t.e0 + 1;
                    e_ready = 1'b0;
                    e_pre   = (k <= P);
                    if (k == P + 1 || k == P + 2) e_wl[t.addr] = 1'b1;
                    if (k == P + 2) begin
                        e_sae = !t.rw;
                        e_wde = t.rw;
                    end
                    if (k >= P + 3) begin
                        e_rdv  = !t.rw;
                        e_perr = !t.rw && PAR_EN && t.perr;
                        if (!t.rw) begin
                            hold = t.data;
                            checkOutput("read_data", 64'(rdata), 64'(t.data));
                        end
                        void'(txn_q.pop_front());
                    end
                end
            end
            checkOutput("strobes",
                64'({ready, precharge, wl, sae, wde, rdata_valid, req_dropped, act_perr}),
                64'({e_ready, e_pre, e_wl, e_sae, e_wde, e_rdv, e_drop, e_perr}));
            checkOutput("rdata_hold", 64'(rdata), 64'(hold));
        end
    end

    initial begin
        bit                r_rw;
        bit                r_inj;
        int                r_addr;
        int                first_e0;
        int                n;
        logic [DATA_W-1:0] r_data;
        rst_n = 1'b1;
        valid = 1'b0;
        rw    = 1'b0;
        addr  = '0;
        wdata = '0;
`ifdef MEM_SEQ_PARITY_EN
        par_inj = 1'b0;
`endif
        clearModel();
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        idle(1);
        rst_n = 1'b1;

        $display("[TB] directed write/read");
        applyStimulus(1'b1, 2, 4'hA, 1'b0);
        applyStimulus(1'b0, 2, 4'h0, 1'b0);
        applyStimulus(1'b0, 1, 4'h0, 1'b0);

        $display("[TB] busy request during precharge");
        applyStimulus(1'b1, 3, 4'h6, 1'b0);
        tryDrop();
        applyStimulus(1'b0, 3, 4'h0, 1'b0);
        applyStimulus(1'b0, 2, 4'h0, 1'b0);

        $display("[TB] reset during ACT of a write");
        applyStimulus(1'b1, 0, 4'h5, 1'b0);
        idle(P);
        resetDut();
        applyStimulus(1'b0, 0, 4'h0, 1'b0);

        $display("[TB] back-to-back writes");
        idle(P + 4);
        applyStimulus(1'b1, 1, 4'h9, 1'b0);
        first_e0 = last_e0;
        applyStimulus(1'b1, 2, 4'hC, 1'b0);
        checkOutput("b2b_spacing", 64'(last_e0 - first_e0), 64'(P + 4));
        applyStimulus(1'b0, 1, 4'h0, 1'b0);
        applyStimulus(1'b0, 2, 4'h0, 1'b0);

        $display("[TB] parity injection");
        applyStimulus(1'b1, 1, 4'h3, 1'b1);
        applyStimulus(1'b0, 1, 4'h0, 1'b0);
        applyStimulus(1'b1, 1, 4'h3, 1'b0);
        applyStimulus(1'b0, 1, 4'h0, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 80; i++) begin
            r_rw   = 1'($urandom);
            r_addr = $urandom_range(0, DEPTH - 1);
            r_data = DATA_W'($urandom);
            r_inj  = ($urandom_range(0, 3) == 0);
            applyStimulus(r_rw, r_addr, r_data, r_inj);
            if ($urandom_range(0, 3) == 0) begin
                idle($urandom_range(0, P + 1));
                tryDrop();
            end
            idle($urandom_range(0, 2));
        end

        n = 0;
        while ((txn_q.size() > 0 || drop_q.size() > 0) && n < 50) begin
            idle(1);
            n++;
        end
        idle(3);
        checkOutput("scoreboard_empty", 64'(txn_q.size() + drop_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
